// File: rtl/seq_mult_if.sv
// Request/result bundle for seq_mult: start/a/b in, busy/done/product out.
// Latency: n/a (signal grouping only).
// Backpressure: none; the requester must watch busy, because start is ignored while it is high.
interface seq_mult_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start,
        output a,
        output b,
        input  busy,
        input  done,
        input  product
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output busy,
        output done,
        output product
    );
endinterface

// File: rtl/seq_mult.sv
// Shift-add sequential multiplier, one partial product per cycle; SEQ_MULT_SIGNED_EN selects two's-complement operands.
// Latency: done pulses in the cycle after edge T+WIDTH when start is accepted at edge T.
// Backpressure: none; start is ignored while busy, and product holds until the next completion.
module seq_mult #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_mult_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     working;
    logic [CW-1:0]        count;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   shifted;
    logic [2*WIDTH-1:0]   final_prod;
    logic                 last;

`ifdef SEQ_MULT_SIGNED_EN
    logic                 sign;

    // Magnitudes are taken at start; -MIN wraps to MIN, which is still the right unsigned magnitude.
    assign a_mag      = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign b_mag      = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign final_prod = sign ? -shifted : shifted;
`else
    assign a_mag      = bus.a;
    assign b_mag      = bus.b;
    assign final_prod = shifted;
`endif

    // Carry is kept as the top bit of sum and shifted into acc, so no product bit is lost.
    always_comb begin
        sum = {1'b0, acc};
        if (working[0]) begin
            sum = {1'b0, acc} + {1'b0, mcand};
        end
    end

    assign shifted = {sum, working[WIDTH-1:1]};
    assign last    = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            acc       <= '0;
            working   <= '0;
            count     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand   <= a_mag;
                        working <= b_mag;
                        acc     <= '0;
                        count   <= '0;
                        busy_q  <= 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
                        sign    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc     <= shifted[2*WIDTH-1:WIDTH];
                    working <= shifted[WIDTH-1:0];
                    count   <= count + CW'(1);
                    if (last) begin
                        product_q <= final_prod;
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule
